branch_pred_ctrl: RTL
=====================

Name: branch_pred_ctrl

Overview:
Branch prediction and redirect controller for the 5-stage pipeline. It holds a direct-mapped branch history/target table of 2-bit saturating counters and gives IF a taken/target prediction. It compares the EX-stage branch evaluation result (taken flag plus computed target) against the prediction carried down the pipe. On a mismatch it issues the PC redirect and the IF/ID flush, and it updates the table when EX retires a branch.

Parameters:
ENTRIES, 16, number of table entries; power of two, minimum 2.
IDX_W, log2(ENTRIES) = 4, index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
if_pc  in  32  fetch PC.
pred_taken  out  1  IF prediction: taken.
pred_target  out  32  IF predicted next PC.
ex_valid  in  1  EX stage holds a valid instruction.
ex_stall  in  1  EX is held this cycle; no update, no redirect.
ex_is_branch  in  1  EX instruction is a conditional branch.
ex_pc  in  32  PC of the EX instruction.
ex_taken  in  1  branch evaluation result from EX.
ex_target  in  32  computed branch target (pc+imm).
ex_pred_taken  in  1  prediction made for this instruction at IF.
ex_pred_target  in  32  predicted target carried from IF.
redirect  out  1  mispredict: PC must load redirect_pc.
redirect_pc  out  32  corrected next PC.
flush  out  1  squash IF/ID; equals redirect.

Behaviour:
- Entry state: valid, tag, target[31:0], ctr[1:0]. The table is the only sequential state, apart from the optional counters.
- Reset (sync, rst=1 at the edge): all valid cleared and all ctr set to 2'b01. While rst=1, pred_taken=0, pred_target=if_pc+4, redirect=0, flush=0, redirect_pc=0.
- Prediction (combinational, 0-cycle):
  - hit = valid[idx] && tag matches.
  - If hit && ctr[1]: pred_taken=1, pred_target=target[idx].
  - Otherwise pred_taken=0, pred_target=if_pc+4.
- Read/write collision on the same index in the same cycle: the prediction uses the pre-update contents. The update is visible from the next cycle.
- Resolve condition: go = ex_valid && !ex_stall.
- Mispredict, when go:
  - If ex_is_branch: (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target).
  - If !ex_is_branch: mispredict = ex_pred_taken (an alias or stale entry).
- redirect = flush = mispredict, combinational in the EX cycle.
- redirect_pc = ex_target when (ex_is_branch && ex_taken); otherwise ex_pc+4. It is 0 when redirect=0.
- Update at the clock edge when go, indexed by ex_pc:
  - Branch, hit: ctr saturating +1 if taken, -1 if not taken (3 stays 3, 0 stays 0). Target rewritten with ex_target if taken.
  - Branch, miss, taken: allocate, overwriting any tag. Set valid=1, tag, target=ex_target, ctr=2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch with ex_pred_taken=1 and hit: clear valid.
- ex_stall=1 or ex_valid=0: no table write, redirect=0.
- All PC arithmetic is 32-bit, wrap-around modulo 2^32 (0xFFFFFFFC+4 = 0).
- rst asserted mid-stream overrides any same-cycle update. The table ends the cycle in its reset state.

Optional Feature:
Macro BRANCH_PRED_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on go && ex_is_branch.
  - stat_mispredicts increments on go && mispredict.
  - Both cleared by rst and wrap at 2^32.
- Undefined: no ports, no counters; table and redirect behaviour are identical.

Test Plan:
1. Post-reset prediction: after reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, redirect=0.
2. Mispredict and allocate: EX ex_pc=0x100, ex_is_branch=1, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> same cycle redirect=1, flush=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
3. Saturation and hysteresis on 0x100 (ctr=10):
   - Two taken resolves -> ctr=11.
   - One not-taken -> ctr=10, still predicts taken.
   - Second not-taken -> ctr=01, pred_taken=0.
   - Third not-taken -> ctr=00.
   - One taken -> ctr=01, pred_taken still 0.
4. Alias miss and stale-entry clear:
   - With the 0x100 entry valid, if_pc=0x140 (same index 0, different tag) -> pred_taken=0, pred_target=0x144.
   - EX ex_pc=0x100, ex_is_branch=0, ex_pred_taken=1 -> redirect=1, redirect_pc=0x104, entry cleared.
5. Stall gating: mispredict inputs as in test 2 with ex_stall=1 -> redirect=0, table unchanged. Deassert ex_stall -> redirect=1, redirect_pc=0x80.
6. Reset mid-operation: rst=1 in the same cycle as an allocate of 0x200 -> next cycle if_pc=0x200 gives pred_taken=0. With BRANCH_PRED_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// Branch predictor with a direct-mapped table of 2-bit counters and EX-stage redirect.
// Optional statistics counters: define BRANCH_PRED_STATS_EN.
module branch_pred_ctrl #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             go;
  logic             mispredict;

  logic             wr_en;
  logic             valid_d;
  logic [31:0]      target_d;
  logic [1:0]       ctr_d;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Reset masks resolution so neither a redirect nor a table write leaks out of a reset cycle.
  assign go = ex_valid && !ex_stall && !rst;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (!rst && if_hit && ctr_q[if_idx][1]) begin
      pred_taken  = 1'b1;
      pred_target = target_q[if_idx];
    end
  end

  always_comb begin
    mispredict = 1'b0;
    if (go) begin
      if (ex_is_branch) begin
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_pred_target != ex_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
    end
  end

  assign redirect = mispredict;
  assign flush    = mispredict;

  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q[ex_idx];
    target_d = target_q[ex_idx];
    ctr_d    = ctr_q[ex_idx];
    if (go) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          wr_en = 1'b1;
          if (ex_taken) begin
            ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
            target_d = ex_target;
          end else begin
            ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          wr_en    = 1'b1;
          valid_d  = 1'b1;
          target_d = ex_target;
          ctr_d    = 2'b10;
        end
      end else if (ex_pred_taken && ex_hit) begin
        wr_en   = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= valid_d;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= target_d;
      ctr_q[ex_idx]    <= ctr_d;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (go && ex_is_branch) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict)         stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
